iq_sample_player: RTL

Parametrised I/Q stimulus player for the demodulator/CORDIC/CDR chain. It stores up to DEPTH complex samples loaded through a write port, then replays them at a programmable sample period, emitting one `eoc` strobe per sample. It supports one-shot and loop modes, start/stop control, and done/wrap status. It drives the `I_IF`/`Q_IF`/`eoc` inputs of `decoder_cordic_cdr` in benches and in FPGA self-test builds.

---
 rtl/iq_sample_player.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/iq_sample_player.sv
// I/Q stimulus player.
//
// Holds up to DEPTH complex samples that are loaded through a simple write port.
// On start, it replays entries 0..last_addr, one sample every `period` clocks.
// Each emitted sample is marked by a one-cycle `eoc` strobe.
// Playback is either one-shot (ends with a `done` pulse) or looping (`wrap` pulse on each
// new pass). A `stop` pulse aborts playback.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_i/wr_q  sample load port (IDLE only, out-of-range addresses dropped)
//   start, stop           playback control pulses (stop has priority)
//   loop_mode, period, last_addr  playback configuration, latched at start
//   i_out, q_out, eoc     sample stream (data is zero outside eoc cycles)
//   busy, done, wrap      status
module iq_sample_player #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned DEPTH    = 1000,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_i,
    input  logic [DATA_W-1:0]   wr_q,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [ADDR_W-1:0]   last_addr,
    output logic [DATA_W-1:0]   i_out,
    output logic [DATA_W-1:0]   q_out,
    output logic                eoc,
    output logic                busy,
    output logic                done,
    output logic                wrap
);

    localparam logic [ADDR_W-1:0] LastMax = ADDR_W'(DEPTH - 1);

    typedef enum logic {StIdle, StPlay} state_e;

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [PERIOD_W-1:0]   period_m1_q, period_m1_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     last_q, last_d;
    logic                  loop_q, loop_d;
    logic                  wrap_pend_q, wrap_pend_d;
    logic [DATA_W-1:0]     i_out_q, i_out_d;
    logic [DATA_W-1:0]     q_out_q, q_out_d;
    logic                  eoc_q, eoc_d;
    logic                  done_q, done_d;
    logic                  wrap_q, wrap_d;
    logic                  mem_we;

    logic [2*DATA_W-1:0]   mem [DEPTH];
    logic [2*DATA_W-1:0]   rd_data_q;

    // Synchronous-read memory. The read address is the next-state address, so rd_data_q
    // always holds entry[addr_q] and the emitting edge can use it directly (no bubbles at
    // period 1). A write that lands on the address being fetched is forwarded, so a write
    // to entry 0 in the same cycle as start is played.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= {wr_i, wr_q};
        end
        if (mem_we && (wr_addr == addr_d)) begin
            rd_data_q <= {wr_i, wr_q};
        end else begin
            rd_data_q <= mem[addr_d];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_m1_d = period_m1_q;
        addr_d      = addr_q;
        last_d      = last_q;
        loop_d      = loop_q;
        wrap_pend_d = wrap_pend_q;
        i_out_d     = '0;
        q_out_d     = '0;
        eoc_d       = 1'b0;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                mem_we = wr_en && (32'(wr_addr) < DEPTH);
                if (start && !stop) begin
                    state_d     = StPlay;
                    cnt_d       = '0;
                    addr_d      = '0;
                    wrap_pend_d = 1'b0;
                    loop_d      = loop_mode;
                    period_m1_d = (period == '0) ? '0 : period - PERIOD_W'(1);
                    last_d      = (32'(last_addr) > DEPTH - 1) ? LastMax : last_addr;
                end
            end
            StPlay: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == period_m1_q) begin
                    eoc_d                = 1'b1;
                    {i_out_d, q_out_d}   = rd_data_q;
                    wrap_d               = wrap_pend_q;
                    wrap_pend_d          = 1'b0;
                    cnt_d                = '0;
                    if (addr_q == last_q) begin
                        addr_d = '0;
                        if (loop_q) begin
                            wrap_pend_d = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            period_m1_q <= '0;
            addr_q      <= '0;
            last_q      <= '0;
            loop_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            eoc_q       <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_m1_q <= period_m1_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            loop_q      <= loop_d;
            wrap_pend_q <= wrap_pend_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            eoc_q       <= eoc_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign i_out = i_out_q;
    assign q_out = q_out_q;
    assign eoc   = eoc_q;
    assign done  = done_q;
    assign wrap  = wrap_q;
    assign busy  = (state_q == StPlay);

endmodule
